// File: rtl/wishbone_pkg.sv
// rtl/wishbone_pkg.sv - shared types and defaults for the Wishbone shared bus
package wishbone_pkg;

   localparam int WB_DATA_W = 32;
   localparam int WB_ADDR_W = 32;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DECERR,
      TOERR
   } bus_state_e;

   typedef struct packed {
      logic cyc;
      logic stb;
      logic we;
      logic lock;
   } wb_req_ctl_t;

   typedef struct packed {
      logic ack;
      logic err;
      logic rty;
   } wb_resp_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin pick of the first requester after the pointer
module rr_arbiter #(
   parameter int N     = 2,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N-1:0]     gnt_o,
   output logic [IDX_W-1:0] idx_o
);

   // Two passes: indices above the pointer first, then wrap to the bottom.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      for (int i = 0; i < N; i++) begin
         if (~|gnt_o && req_i[i] && (i > int'(ptr_i))) begin
            gnt_o[i] = 1'b1;
            idx_o    = IDX_W'(i);
         end
      end
      for (int i = 0; i < N; i++) begin
         if (~|gnt_o && req_i[i] && (i <= int'(ptr_i))) begin
            gnt_o[i] = 1'b1;
            idx_o    = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/wishbone_shared_bus.sv
// rtl/wishbone_shared_bus.sv - N-master/N-slave Wishbone classic shared bus
module wishbone_shared_bus
   import wishbone_pkg::*;
#(
   parameter int N_MASTER = 2,
   parameter int N_SLAVE  = 4,
   parameter int DATA_W   = WB_DATA_W,
   parameter int ADDR_W   = WB_ADDR_W,
   parameter int TIMEOUT  = 255
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic [N_SLAVE*ADDR_W-1:0]       SSTART_ADDR,
   input  logic [N_SLAVE*ADDR_W-1:0]       SEND_ADDR,
   input  logic [N_MASTER*DATA_W-1:0]      ms_dat_i,
   input  logic [N_MASTER*ADDR_W-1:0]      ms_adr_i,
   input  logic [N_MASTER*(DATA_W/8)-1:0]  ms_sel_i,
   input  logic [N_MASTER-1:0]             ms_we_i,
   input  logic [N_MASTER-1:0]             ms_cyc_i,
   input  logic [N_MASTER-1:0]             ms_stb_i,
   input  logic [N_MASTER-1:0]             mi_lock_i,
   output logic [N_MASTER-1:0]             im_gnt_o,
   output logic [N_MASTER*DATA_W-1:0]      sm_dat_o,
   output logic [N_MASTER-1:0]             sm_ack_o,
   output logic [N_MASTER-1:0]             sm_err_o,
   output logic [N_MASTER-1:0]             sm_rty_o,
   output logic [DATA_W-1:0]               ms_dat_o,
   output logic [ADDR_W-1:0]               ms_adr_o,
   output logic [DATA_W/8-1:0]             ms_sel_o,
   output logic                            ms_we_o,
   output logic [N_SLAVE-1:0]              ms_cyc_o,
   output logic [N_SLAVE-1:0]              ms_stb_o,
   input  logic [N_SLAVE*DATA_W-1:0]       sl_dat_i,
   input  logic [N_SLAVE-1:0]              sl_ack_i,
   input  logic [N_SLAVE-1:0]              sl_err_i,
   input  logic [N_SLAVE-1:0]              sl_rty_i
);

   localparam int SEL_W = DATA_W / 8;
   localparam int IDX_W = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;

   bus_state_e           state_q, state_d;
   logic [N_MASTER-1:0]  gnt_q, gnt_d;
   logic [IDX_W-1:0]     ptr_q, ptr_d;

   logic [N_MASTER-1:0]  arb_gnt;
   logic [IDX_W-1:0]     arb_idx;

   logic [DATA_W-1:0]    dat_g;
   logic [ADDR_W-1:0]    adr_g;
   logic [SEL_W-1:0]     sel_g;
   wb_req_ctl_t          ctl_g;

   logic [N_SLAVE-1:0]   hit;
   logic                 any_hit;
   wb_resp_t             sl_resp;
   logic [DATA_W-1:0]    sl_dat;

   logic                 in_busy_stb;
   logic                 resp_ack, resp_err, resp_rty;
   logic                 wd_pending, wd_expire;

   rr_arbiter #(
      .N     (N_MASTER),
      .IDX_W (IDX_W)
   ) u_arb (
      .req_i (ms_cyc_i),
      .ptr_i (ptr_q),
      .gnt_o (arb_gnt),
      .idx_o (arb_idx)
   );

   // Granted master's request; all zero while nobody holds the grant.
   always_comb begin
      dat_g = '0;
      adr_g = '0;
      sel_g = '0;
      ctl_g = '0;
      for (int m = 0; m < N_MASTER; m++) begin
         if (gnt_q[m]) begin
            dat_g     = ms_dat_i[m*DATA_W +: DATA_W];
            adr_g     = ms_adr_i[m*ADDR_W +: ADDR_W];
            sel_g     = ms_sel_i[m*SEL_W +: SEL_W];
            ctl_g.cyc = ms_cyc_i[m];
            ctl_g.stb = ms_stb_i[m];
            ctl_g.we  = ms_we_i[m];
            ctl_g.lock = mi_lock_i[m];
         end
      end
   end

   always_comb begin
      hit = '0;
      for (int s = 0; s < N_SLAVE; s++) begin
         if (~|hit && (adr_g >= SSTART_ADDR[s*ADDR_W +: ADDR_W])
                   && (adr_g <= SEND_ADDR[s*ADDR_W +: ADDR_W])) begin
            hit[s] = 1'b1;
         end
      end
   end

   assign any_hit = |hit;

   always_comb begin
      sl_resp = '0;
      sl_dat  = '0;
      for (int s = 0; s < N_SLAVE; s++) begin
         if (hit[s]) begin
            sl_resp.ack = sl_ack_i[s];
            sl_resp.err = sl_err_i[s];
            sl_resp.rty = sl_rty_i[s];
            sl_dat      = sl_dat_i[s*DATA_W +: DATA_W];
         end
      end
   end

   assign in_busy_stb = (state_q == BUSY) && ctl_g.stb;
   assign resp_ack    = in_busy_stb && sl_resp.ack;
   assign resp_rty    = in_busy_stb && sl_resp.rty;
   assign resp_err    = (in_busy_stb && sl_resp.err) || (state_q == DECERR) || (state_q == TOERR);

   assign ms_dat_o = dat_g;
   assign ms_adr_o = adr_g;
   assign ms_sel_o = sel_g;
   assign ms_we_o  = ctl_g.we;
   assign ms_cyc_o = ((state_q == BUSY) && ctl_g.cyc) ? hit : '0;
   assign ms_stb_o = in_busy_stb ? hit : '0;

   assign im_gnt_o = gnt_q;
   assign sm_ack_o = resp_ack ? gnt_q : '0;
   assign sm_err_o = resp_err ? gnt_q : '0;
   assign sm_rty_o = resp_rty ? gnt_q : '0;

   always_comb begin
      sm_dat_o = '0;
      for (int m = 0; m < N_MASTER; m++) begin
         sm_dat_o[m*DATA_W +: DATA_W] = (gnt_q[m] && in_busy_stb) ? sl_dat : '0;
      end
   end

   assign wd_pending = in_busy_stb && any_hit && !(sl_resp.ack || sl_resp.err || sl_resp.rty);

   generate
      if (TIMEOUT > 0) begin : g_wd
         localparam int WD_W = $clog2(TIMEOUT + 1);
         logic [WD_W-1:0] wd_q, wd_d, wd_inc;

         assign wd_inc    = wd_q + WD_W'(1);
         // A response in the expiry cycle removes wd_pending, so the ack wins.
         assign wd_expire = wd_pending && (wd_inc == WD_W'(TIMEOUT));

         always_comb begin
            wd_d = '0;
            if (wd_pending && !wd_expire) begin
               wd_d = wd_inc;
            end
         end

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               wd_q <= '0;
            end else begin
               wd_q <= wd_d;
            end
         end
      end else begin : g_no_wd
         assign wd_expire = 1'b0;
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: begin
            if (|ms_cyc_i) begin
               state_d = BUSY;
               gnt_d   = arb_gnt;
               ptr_d   = arb_idx;
            end
         end
         BUSY: begin
            if (!ctl_g.cyc && !ctl_g.lock) begin
               state_d = IDLE;
               gnt_d   = '0;
            end else if (ctl_g.stb && !any_hit) begin
               state_d = DECERR;
            end else if (wd_expire) begin
               state_d = TOERR;
            end
         end
         DECERR:  state_d = BUSY;
         TOERR:   state_d = BUSY;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         ptr_q   <= IDX_W'(N_MASTER - 1);
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         ptr_q   <= ptr_d;
      end
   end

endmodule

// File: tb/tb_wishbone_shared_bus.sv
// tb/tb_wishbone_shared_bus.sv - directed bench for the Wishbone shared bus
module tb_wishbone_shared_bus;

   localparam int NM = 2;
   localparam int NS = 4;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int SW = 4;
   localparam int TO = 4;

   logic                clk = 1'b0;
   logic                rst;
   logic [NS*AW-1:0]    sstart, send;
   logic [NM*DW-1:0]    ms_dat_i;
   logic [NM*AW-1:0]    ms_adr_i;
   logic [NM*SW-1:0]    ms_sel_i;
   logic [NM-1:0]       ms_we_i, ms_cyc_i, ms_stb_i, mi_lock_i;
   logic [NM-1:0]       im_gnt_o, sm_ack_o, sm_err_o, sm_rty_o;
   logic [NM*DW-1:0]    sm_dat_o;
   logic [DW-1:0]       ms_dat_o;
   logic [AW-1:0]       ms_adr_o;
   logic [SW-1:0]       ms_sel_o;
   logic                ms_we_o;
   logic [NS-1:0]       ms_cyc_o, ms_stb_o;
   logic [NS*DW-1:0]    sl_dat_i;
   logic [NS-1:0]       sl_ack_i, sl_err_i, sl_rty_i;

   logic [31:0]         m_adr [NM];
   logic [31:0]         m_dat [NM];
   logic [3:0]          m_sel [NM];
   logic [NS-1:0]       ack_en, err_en, rty_en, ack_force;

   assign ms_adr_i = {m_adr[1], m_adr[0]};
   assign ms_dat_i = {m_dat[1], m_dat[0]};
   assign ms_sel_i = {m_sel[1], m_sel[0]};
   assign sl_ack_i = (ms_stb_o & ack_en) | ack_force;
   assign sl_err_i = ms_stb_o & err_en;
   assign sl_rty_i = ms_stb_o & rty_en;

   wishbone_shared_bus #(
      .N_MASTER (NM), .N_SLAVE (NS), .DATA_W (DW), .ADDR_W (AW), .TIMEOUT (TO)
   ) dut (
      .clk_i (clk), .rst_i (rst),
      .SSTART_ADDR (sstart), .SEND_ADDR (send),
      .ms_dat_i (ms_dat_i), .ms_adr_i (ms_adr_i), .ms_sel_i (ms_sel_i), .ms_we_i (ms_we_i),
      .ms_cyc_i (ms_cyc_i), .ms_stb_i (ms_stb_i), .mi_lock_i (mi_lock_i),
      .im_gnt_o (im_gnt_o), .sm_dat_o (sm_dat_o),
      .sm_ack_o (sm_ack_o), .sm_err_o (sm_err_o), .sm_rty_o (sm_rty_o),
      .ms_dat_o (ms_dat_o), .ms_adr_o (ms_adr_o), .ms_sel_o (ms_sel_o), .ms_we_o (ms_we_o),
      .ms_cyc_o (ms_cyc_o), .ms_stb_o (ms_stb_o),
      .sl_dat_i (sl_dat_i), .sl_ack_i (sl_ack_i), .sl_err_i (sl_err_i), .sl_rty_i (sl_rty_i)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          m;
      logic [31:0] adr;
      logic        we;
      logic [31:0] dat;
      int          rsp;      // 0 ack, 1 err, 2 rty
      logic [3:0]  exp_slv;
      logic [31:0] exp_dat;
   } vec_t;

   vec_t vecs [8];
   int   tests = 0;
   int   fails = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic drv(input int m, input logic cyc, input logic stb, input logic lock,
                      input logic [31:0] adr, input logic we, input logic [31:0] dat);
      ms_cyc_i[m[0]]  = cyc;
      ms_stb_i[m[0]]  = stb;
      mi_lock_i[m[0]] = lock;
      ms_we_i[m[0]]   = we;
      m_adr[m[0]]     = adr;
      m_dat[m[0]]     = dat;
      m_sel[m[0]]     = cyc ? 4'hF : 4'h0;
   endtask

   task automatic idle_all();
      drv(0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      drv(1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   function automatic logic [31:0] slot(input int m, input logic [NM*DW-1:0] d);
      return m[0] ? d[63:32] : d[31:0];
   endfunction

   task automatic run_vec(input vec_t v);
      logic [1:0] eg;
      eg     = 2'b01 << v.m;
      ack_en = (v.rsp == 0) ? 4'hF : 4'h0;
      err_en = (v.rsp == 1) ? 4'hF : 4'h0;
      rty_en = (v.rsp == 2) ? 4'hF : 4'h0;
      drv(v.m, 1'b1, 1'b1, 1'b0, v.adr, v.we, v.dat);
      smp();
      chk("vec_gnt_latency", im_gnt_o, 2'b00);
      tick();
      smp();
      chk("vec_gnt", im_gnt_o, eg);
      chk("vec_cyc_o", ms_cyc_o, v.exp_slv);
      chk("vec_stb_o", ms_stb_o, v.exp_slv);
      chk("vec_adr_o", ms_adr_o, v.adr);
      chk("vec_dat_o", ms_dat_o, v.dat);
      chk("vec_sel_o", ms_sel_o, 4'hF);
      chk("vec_we_o", ms_we_o, v.we);
      chk("vec_ack", sm_ack_o, (v.rsp == 0) ? eg : 2'b00);
      chk("vec_err", sm_err_o, (v.rsp == 1) ? eg : 2'b00);
      chk("vec_rty", sm_rty_o, (v.rsp == 2) ? eg : 2'b00);
      chk("vec_rdata", slot(v.m, sm_dat_o), v.exp_dat);
      chk("vec_rdata_other", slot(1 - v.m, sm_dat_o), 32'h0);
      tick();
      drv(v.m, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      smp();
      chk("vec_ack_after_drop", sm_ack_o, 2'b00);
      tick();
      ack_en = 4'hF;
      err_en = 4'h0;
      rty_en = 4'h0;
   endtask

   initial begin
      logic [1:0]  eg;
      logic [31:0] de_adr [2];
      int          w;

      vecs[0] = '{0, 32'h0000_0010, 1'b0, 32'h1111_0000, 0, 4'b0001, 32'hA5A5_0000};
      vecs[1] = '{1, 32'h0000_0150, 1'b1, 32'h2222_0001, 0, 4'b0010, 32'hA5A5_0011};
      vecs[2] = '{0, 32'h0000_1800, 1'b0, 32'h3333_0002, 2, 4'b0100, 32'hA5A5_0022};
      vecs[3] = '{1, 32'h0000_2000, 1'b0, 32'h4444_0003, 1, 4'b1000, 32'hA5A5_0033};
      vecs[4] = '{0, 32'h0000_0080, 1'b1, 32'h5555_0004, 0, 4'b0001, 32'hA5A5_0000};
      vecs[5] = '{1, 32'h0000_00FF, 1'b0, 32'h6666_0005, 0, 4'b0001, 32'hA5A5_0000};
      vecs[6] = '{0, 32'h0000_0100, 1'b0, 32'h7777_0006, 0, 4'b0010, 32'hA5A5_0011};
      vecs[7] = '{1, 32'h0000_2FFF, 1'b1, 32'h8888_0007, 0, 4'b1000, 32'hA5A5_0033};
      de_adr[0] = 32'hDEAD_0000;
      de_adr[1] = 32'h0000_3000;

      sstart    = {32'h0000_0080, 32'h0000_1000, 32'h0000_0100, 32'h0000_0000};
      send      = {32'h0000_2FFF, 32'h0000_1FFF, 32'h0000_01FF, 32'h0000_00FF};
      sl_dat_i  = {32'hA5A5_0033, 32'hA5A5_0022, 32'hA5A5_0011, 32'hA5A5_0000};
      ack_en    = 4'hF;
      err_en    = 4'h0;
      rty_en    = 4'h0;
      ack_force = 4'h0;

      // Reset with both masters already requesting: nothing may leak out.
      rst = 1'b1;
      drv(0, 1'b1, 1'b1, 1'b0, 32'h10, 1'b0, 32'h0);
      drv(1, 1'b1, 1'b1, 1'b0, 32'h10, 1'b0, 32'h0);
      tick();
      tick();
      smp();
      chk("rst_gnt", im_gnt_o, 2'b00);
      chk("rst_cyc_o", ms_cyc_o, 4'h0);
      chk("rst_stb_o", ms_stb_o, 4'h0);
      chk("rst_ack", sm_ack_o, 2'b00);
      chk("rst_err", sm_err_o, 2'b00);
      chk("rst_dat", sm_dat_o, 64'h0);
      chk("rst_adr_o", ms_adr_o, 32'h0);

      // Alternating grants, master 0 first, one IDLE cycle between tenures.
      tick();
      rst = 1'b0;
      smp();
      chk("rr_latency", im_gnt_o, 2'b00);
      for (int r = 0; r < 4; r++) begin
         w  = r % 2;
         eg = 2'b01 << w;
         tick();
         smp();
         chk("rr_gnt", im_gnt_o, eg);
         chk("rr_ack", sm_ack_o, eg);
         tick();
         drv(w, 1'b0, 1'b0, 1'b0, 32'h10, 1'b0, 32'h0);
         smp();
         chk("rr_gnt_hold", im_gnt_o, eg);
         chk("rr_ack_drop", sm_ack_o, 2'b00);
         tick();
         drv(w, 1'b1, 1'b1, 1'b0, 32'h10, 1'b0, 32'h0);
         smp();
         chk("rr_idle_gap", im_gnt_o, 2'b00);
      end
      idle_all();
      tick();

      for (int i = 0; i < 8; i++) begin
         run_vec(vecs[i]);
      end

      // Lock keeps m1 granted across a cyc gap while m0 waits.
      drv(1, 1'b1, 1'b1, 1'b1, 32'h10, 1'b0, 32'h0);
      smp();
      chk("lock_latency", im_gnt_o, 2'b00);
      tick();
      smp();
      chk("lock_gnt", im_gnt_o, 2'b10);
      chk("lock_ack", sm_ack_o, 2'b10);
      tick();
      drv(1, 1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 32'h0);
      drv(0, 1'b1, 1'b1, 1'b0, 32'h150, 1'b0, 32'h0);
      ack_force = 4'b0001;
      for (int k = 0; k < 3; k++) begin
         smp();
         chk("lock_hold_gnt", im_gnt_o, 2'b10);
         chk("lock_hold_cyc_o", ms_cyc_o, 4'h0);
         chk("lock_hold_stb_o", ms_stb_o, 4'h0);
         chk("lock_stray_ack", sm_ack_o, 2'b00);
         tick();
      end
      drv(1, 1'b0, 1'b0, 1'b0, 32'h10, 1'b0, 32'h0);
      ack_force = 4'h0;
      smp();
      chk("unlock_gnt", im_gnt_o, 2'b10);
      tick();
      smp();
      chk("unlock_idle", im_gnt_o, 2'b00);
      tick();
      smp();
      chk("m0_after_lock_gnt", im_gnt_o, 2'b01);
      chk("m0_after_lock_cyc_o", ms_cyc_o, 4'b0010);
      chk("m0_after_lock_ack", sm_ack_o, 2'b01);
      tick();
      idle_all();
      tick();

      // Unmapped addresses: error exactly two cycles after stb, for one cycle.
      for (int k = 0; k < 2; k++) begin
         eg = 2'b01 << k;
         drv(k, 1'b1, 1'b1, 1'b0, de_adr[k], 1'b0, 32'h0);
         smp();
         chk("decerr_t0_err", sm_err_o, 2'b00);
         tick();
         smp();
         chk("decerr_t1_gnt", im_gnt_o, eg);
         chk("decerr_t1_stb_o", ms_stb_o, 4'h0);
         chk("decerr_t1_cyc_o", ms_cyc_o, 4'h0);
         chk("decerr_t1_err", sm_err_o, 2'b00);
         tick();
         smp();
         chk("decerr_t2_err", sm_err_o, eg);
         tick();
         drv(k, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
         smp();
         chk("decerr_t3_err", sm_err_o, 2'b00);
         tick();
      end

      // Silent slave: error after four strobed cycles.
      ack_en = 4'b1011;
      drv(0, 1'b1, 1'b1, 1'b0, 32'h1800, 1'b0, 32'h0);
      smp();
      tick();
      for (int k = 0; k < 4; k++) begin
         smp();
         chk("wd_wait_stb_o", ms_stb_o, 4'b0100);
         chk("wd_wait_err", sm_err_o, 2'b00);
         tick();
      end
      smp();
      chk("wd_toerr_err", sm_err_o, 2'b01);
      chk("wd_toerr_stb_o", ms_stb_o, 4'h0);
      chk("wd_toerr_cyc_o", ms_cyc_o, 4'h0);
      tick();
      smp();
      chk("wd_after_err", sm_err_o, 2'b00);
      chk("wd_after_stb_o", ms_stb_o, 4'b0100);
      tick();
      idle_all();
      tick();

      // Ack on the fourth strobed cycle beats the watchdog.
      drv(0, 1'b1, 1'b1, 1'b0, 32'h1800, 1'b0, 32'h0);
      smp();
      tick();
      for (int k = 0; k < 3; k++) begin
         smp();
         chk("wd_race_wait_err", sm_err_o, 2'b00);
         tick();
      end
      ack_en = 4'hF;
      smp();
      chk("wd_race_ack", sm_ack_o, 2'b01);
      chk("wd_race_err", sm_err_o, 2'b00);
      tick();
      idle_all();
      smp();
      chk("wd_race_no_toerr", sm_err_o, 2'b00);
      tick();

      // Reset in the middle of a pending transfer.
      ack_en = 4'b1011;
      drv(0, 1'b1, 1'b1, 1'b0, 32'h1800, 1'b0, 32'h0);
      smp();
      tick();
      smp();
      chk("midrst_pre_stb_o", ms_stb_o, 4'b0100);
      tick();
      rst = 1'b1;
      tick();
      smp();
      chk("midrst_gnt", im_gnt_o, 2'b00);
      chk("midrst_cyc_o", ms_cyc_o, 4'h0);
      chk("midrst_stb_o", ms_stb_o, 4'h0);
      chk("midrst_ack", sm_ack_o, 2'b00);
      chk("midrst_err", sm_err_o, 2'b00);
      tick();
      smp();
      chk("midrst_hold_gnt", im_gnt_o, 2'b00);
      chk("midrst_hold_err", sm_err_o, 2'b00);
      rst = 1'b0;
      idle_all();
      ack_en = 4'hF;
      tick();
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
